blink_sequencer: RTL and testbench

- Downstream consumer of the timebase counter's single-cycle timeout pulse.
- Turns a stream of timebase ticks into a finite LED blink pattern: N blinks, each ON for a programmed number of ticks, separated by OFF gaps of a programmed number of ticks.
- Start/busy/done handshake toward the control logic; drives the LED output directly.

---
 rtl/blink_sequencer_if.sv | 35 +++
 rtl/blink_sequencer.sv | 109 ++++++++++
 tb/tb_blink_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/blink_sequencer_if.sv
// Control-side bundle for blink_sequencer: tick/start/config in, LED/status out.
// i_pause exists only when BLINK_PAUSE_EN is defined.
interface blink_sequencer_if #(
  parameter int PH_W  = 4,
  parameter int CNT_W = 4
);
  logic             i_tick;
  logic             i_start;
  logic [PH_W-1:0]  i_on_ticks;
  logic [PH_W-1:0]  i_off_ticks;
  logic [CNT_W-1:0] i_blinks;
`ifdef BLINK_PAUSE_EN
  logic             i_pause;
`endif
  logic             o_led;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_blink_cnt;

  modport master (
    output i_tick, i_start, i_on_ticks, i_off_ticks, i_blinks,
`ifdef BLINK_PAUSE_EN
    output i_pause,
`endif
    input  o_led, o_busy, o_done, o_blink_cnt
  );

  modport slave (
    input  i_tick, i_start, i_on_ticks, i_off_ticks, i_blinks,
`ifdef BLINK_PAUSE_EN
    input  i_pause,
`endif
    output o_led, o_busy, o_done, o_blink_cnt
  );
endinterface

// File: rtl/blink_sequencer.sv
// Turns timebase ticks into N LED blinks of programmed ON/OFF tick lengths.
// Optional feature: define BLINK_PAUSE_EN to add i_pause, which freezes a running sequence.
module blink_sequencer #(
  parameter int PH_W  = 4,
  parameter int CNT_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  blink_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_t;

  state_t           state, state_next;
  logic [PH_W-1:0]  ph_cnt, ph_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic [PH_W-1:0]  on_q, off_q;
  logic [CNT_W-1:0] blinks_q;
  logic             load;
  logic             tick_en;
  logic             last_blink;
  logic             led_q, busy_q, done_q;

`ifdef BLINK_PAUSE_EN
  // Gating the tick alone is enough: ON/OFF only advance on ticks, IDLE/DONE ignore them.
  assign tick_en = bus.i_tick & ~bus.i_pause;
`else
  assign tick_en = bus.i_tick;
`endif

  assign last_blink = ({1'b0, cnt_q} + (CNT_W+1)'(1)) == {1'b0, blinks_q};

  // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    ph_next    = ph_cnt;
    cnt_next   = cnt_q;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.i_start) begin
          load     = 1'b1;
          ph_next  = '0;
          cnt_next = '0;
          state_next = (bus.i_blinks == '0 || bus.i_on_ticks == '0) ? S_DONE : S_ON;
        end
      end
      S_ON: begin
        if (tick_en) begin
          if (ph_cnt == on_q - PH_W'(1)) begin
            ph_next  = '0;
            cnt_next = cnt_q + CNT_W'(1);
            if (last_blink)        state_next = S_DONE;
            else if (off_q == '0)  state_next = S_ON;
            else                   state_next = S_OFF;
          end else begin
            ph_next = ph_cnt + PH_W'(1);
          end
        end
      end
      S_OFF: begin
        if (tick_en) begin
          if (ph_cnt == off_q - PH_W'(1)) begin
            ph_next    = '0;
            state_next = S_ON;
          end else begin
            ph_next = ph_cnt + PH_W'(1);
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      ph_cnt   <= '0;
      cnt_q    <= '0;
      on_q     <= '0;
      off_q    <= '0;
      blinks_q <= '0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_next;
      ph_cnt <= ph_next;
      cnt_q  <= cnt_next;
      if (load) begin
        on_q     <= bus.i_on_ticks;
        off_q    <= bus.i_off_ticks;
        blinks_q <= bus.i_blinks;
      end
      // Outputs are decoded from the next state so they change on the same edge as the state.
      led_q  <= (state_next == S_ON);
      busy_q <= (state_next == S_ON) || (state_next == S_OFF);
      done_q <= (state_next == S_DONE);
    end
  end

  assign bus.o_led       = led_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_blink_cnt = cnt_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed self-checking bench for blink_sequencer; covers the pause path when BLINK_PAUSE_EN is defined.
module tb_blink_sequencer;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  blink_sequencer_if #(.PH_W(4), .CNT_W(4)) bus ();

  blink_sequencer #(.PH_W(4), .CNT_W(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // on=2, off=3, blinks=3, one tick every 4 cycles; noise pulses start and rewrites config mid-run.
  task automatic basic_run(input bit noise);
    int led_tab[12] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
    int cnt_tab[12] = '{0, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 3};
    bus.i_on_ticks  = 4'd2;
    bus.i_off_ticks = 4'd3;
    bus.i_blinks    = 4'd3;
    bus.i_start     = 1'b1;
    bus.i_tick      = 1'b1;
    cycle();
    bus.i_start = 1'b0;
    bus.i_tick  = 1'b0;
    check("start_led", bus.o_led, 1);
    check("start_busy", bus.o_busy, 1);
    check("start_cnt", bus.o_blink_cnt, 0);
    check("start_done", bus.o_done, 0);
    for (int t = 0; t < 12; t++) begin
      for (int g = 0; g < 3; g++) begin
        bus.i_start = noise;
        if (noise) begin
          bus.i_on_ticks  = 4'd7;
          bus.i_off_ticks = 4'd0;
          bus.i_blinks    = 4'd1;
        end
        cycle();
        check("gap_led", bus.o_led, (t == 0) ? 1 : led_tab[t-1]);
      end
      bus.i_start = 1'b0;
      bus.i_tick  = 1'b1;
      cycle();
      bus.i_tick = 1'b0;
      check("tick_led", bus.o_led, led_tab[t]);
      check("tick_cnt", bus.o_blink_cnt, cnt_tab[t]);
      check("tick_done", bus.o_done, (t == 11) ? 1 : 0);
      check("tick_busy", bus.o_busy, (t == 11) ? 0 : 1);
    end
    bus.i_start = noise;
    cycle();
    bus.i_start = 1'b0;
    check("post_done", bus.o_done, 0);
    check("post_led", bus.o_led, 0);
    check("post_busy", bus.o_busy, 0);
    check("post_cnt", bus.o_blink_cnt, 3);
    cycle();
    check("no_restart_busy", bus.o_busy, 0);
    check("no_restart_led", bus.o_led, 0);
  endtask

  task automatic degen_run(input logic [3:0] on, input logic [3:0] n);
    bus.i_on_ticks  = on;
    bus.i_off_ticks = 4'd1;
    bus.i_blinks    = n;
    bus.i_start     = 1'b1;
    cycle();
    bus.i_start = 1'b0;
    check("degen_done", bus.o_done, 1);
    check("degen_led", bus.o_led, 0);
    check("degen_busy", bus.o_busy, 0);
    check("degen_cnt", bus.o_blink_cnt, 0);
    bus.i_tick = 1'b1;
    cycle();
    bus.i_tick = 1'b0;
    check("degen_done_end", bus.o_done, 0);
    check("degen_led_end", bus.o_led, 0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.i_tick      = 1'b0;
    bus.i_start     = 1'b0;
    bus.i_on_ticks  = '0;
    bus.i_off_ticks = '0;
    bus.i_blinks    = '0;
`ifdef BLINK_PAUSE_EN
    bus.i_pause     = 1'b0;
`endif
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_led", bus.o_led, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_cnt", bus.o_blink_cnt, 0);

    basic_run(1'b0);
    basic_run(1'b1);

    // Merged blinks: on=1, off=0, blinks=4, tick held high (also a fresh start after the noisy run).
    bus.i_on_ticks  = 4'd1;
    bus.i_off_ticks = 4'd0;
    bus.i_blinks    = 4'd4;
    bus.i_start     = 1'b1;
    bus.i_tick      = 1'b1;
    cycle();
    bus.i_start = 1'b0;
    check("merge_start_led", bus.o_led, 1);
    check("merge_start_cnt", bus.o_blink_cnt, 0);
    for (int i = 1; i <= 4; i++) begin
      cycle();
      check("merge_cnt", bus.o_blink_cnt, i);
      check("merge_led", bus.o_led, (i < 4) ? 1 : 0);
      check("merge_done", bus.o_done, (i == 4) ? 1 : 0);
    end
    bus.i_tick = 1'b0;
    cycle();

    degen_run(4'd2, 4'd0);
    degen_run(4'd0, 4'd5);

    // Reset during the OFF gap that follows blink 2.
    bus.i_on_ticks  = 4'd2;
    bus.i_off_ticks = 4'd3;
    bus.i_blinks    = 4'd3;
    bus.i_start     = 1'b1;
    cycle();
    bus.i_start = 1'b0;
    bus.i_tick  = 1'b1;
    for (int i = 0; i < 7; i++) cycle();
    check("pre_rst_led", bus.o_led, 0);
    check("pre_rst_busy", bus.o_busy, 1);
    check("pre_rst_cnt", bus.o_blink_cnt, 2);
    rst = 1'b1;
    #2;
    check("rst_no_edge_cnt", bus.o_blink_cnt, 2);
    check("rst_no_edge_busy", bus.o_busy, 1);
    cycle();
    check("mid_rst_led", bus.o_led, 0);
    check("mid_rst_busy", bus.o_busy, 0);
    check("mid_rst_done", bus.o_done, 0);
    check("mid_rst_cnt", bus.o_blink_cnt, 0);
    rst        = 1'b0;
    bus.i_tick = 1'b0;
    cycle();
    check("after_rst_done", bus.o_done, 0);
    check("after_rst_busy", bus.o_busy, 0);

`ifdef BLINK_PAUSE_EN
    begin
      int n;
      bus.i_on_ticks  = 4'd2;
      bus.i_off_ticks = 4'd2;
      bus.i_blinks    = 4'd2;
      bus.i_start     = 1'b1;
      cycle();
      bus.i_start = 1'b0;
      bus.i_tick  = 1'b1;
      cycle();
      check("pause_pre_led", bus.o_led, 1);
      bus.i_pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
        cycle();
        check("pause_led", bus.o_led, 1);
        check("pause_busy", bus.o_busy, 1);
        check("pause_cnt", bus.o_blink_cnt, 0);
      end
      bus.i_pause = 1'b0;
      n = 0;
      while (!bus.o_done && n < 40) begin
        cycle();
        n++;
        if (n == 1) check("pause_resume_led", bus.o_led, 0);
      end
      check("pause_len", n, 5);
      check("pause_cnt_end", bus.o_blink_cnt, 2);
      bus.i_tick = 1'b0;
      cycle();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
